// File: rtl/stream_demux_if.sv
// stream_demux_if: input stream, N registered output streams and drop status for stream_demux
interface stream_demux_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 3
);
  localparam int SEL_W = $clog2(N_OUT);
  logic [DATA_W-1:0]       s_data;
  logic                    s_valid;
  logic                    s_last;
  logic                    s_ready;
  logic [SEL_W-1:0]        sel;
  logic [N_OUT*DATA_W-1:0] m_data;
  logic [N_OUT-1:0]        m_valid;
  logic [N_OUT-1:0]        m_last;
  logic [N_OUT-1:0]        m_ready;
  logic                    err_sel;
  logic [7:0]              drop_count;
  modport master (
    output s_data, s_valid, s_last, sel, m_ready,
    input  s_ready, m_data, m_valid, m_last, err_sel, drop_count
  );
  modport slave (
    input  s_data, s_valid, s_last, sel, m_ready,
    output s_ready, m_data, m_valid, m_last, err_sel, drop_count
  );
endinterface

// File: rtl/stream_demux.sv
// stream_demux: packet-aware 1:N valid/ready demultiplexer that drops and counts out-of-range packets
module stream_demux #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 3
) (
  input logic           clk,
  input logic           rst,
  stream_demux_if.slave bus
);
  localparam int SEL_W = $clog2(N_OUT);
  localparam int SEL_N = 1 << SEL_W;
  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;
  state_t                  state;
  logic [SEL_W-1:0]        cur_sel;
  logic [SEL_W-1:0]        tgt;
  logic [N_OUT-1:0]        m_valid;
  logic [N_OUT-1:0]        m_last;
  logic [N_OUT*DATA_W-1:0] m_data;
  logic [N_OUT-1:0]        can_acc;
  logic [N_OUT-1:0]        load;
  logic [SEL_N-1:0]        can_pad;
  logic                    in_range;
  logic                    drop_now;
  logic                    ready;
  logic                    acc;
  logic                    first_drop;
  logic                    err_sel;
  logic [7:0]              drop_count;
  // can_pad widens can_acc so an out-of-range tgt never indexes past the vector
  always_comb begin
    can_acc    = ~m_valid | bus.m_ready;
    can_pad    = SEL_N'(can_acc);
    in_range   = 32'(bus.sel) < N_OUT;
    tgt        = state == IDLE ? bus.sel : cur_sel;
    drop_now   = state == DROP || (state == IDLE && !in_range);
    ready      = !rst && (drop_now || can_pad[tgt]);
    acc        = bus.s_valid && ready;
    first_drop = acc && state == IDLE && !in_range;
    load       = acc && !drop_now ? N_OUT'(1) << tgt : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= '0;
      m_last  <= '0;
      m_data  <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (load[i]) begin
          m_valid[i]                  <= 1'b1;
          m_last[i]                   <= bus.s_last;
          m_data[i*DATA_W +: DATA_W]  <= bus.s_data;
        end else if (bus.m_ready[i]) begin
          m_valid[i] <= 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_sel    <= '0;
      err_sel    <= 1'b0;
      drop_count <= '0;
    end else begin
      err_sel <= first_drop;
      if (state == IDLE && bus.s_valid && in_range) cur_sel <= bus.sel;
      if (first_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (acc) state <= bus.s_last ? IDLE : state != IDLE ? state : in_range ? ROUTE : DROP;
    end
  end
  assign bus.s_ready    = ready;
  assign bus.m_valid    = m_valid;
  assign bus.m_last     = m_last;
  assign bus.m_data     = m_data;
  assign bus.err_sel    = err_sel;
  assign bus.drop_count = drop_count;
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: table-driven directed check of stream_demux routing, backpressure, drops and reset
module tb_stream_demux;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic [1:0]  sel;
    logic [2:0]  mr;
    logic        er;
    logic [2:0]  emv;
    logic [23:0] emd;
    logic [2:0]  eml;
    logic        ee;
    logic [7:0]  edc;
  } vec_t;
  vec_t tbl[$];
  stream_demux_if #(.DATA_W(8), .N_OUT(3)) bus ();
  stream_demux #(.DATA_W(8), .N_OUT(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic l, logic [1:0] s, logic [2:0] mr,
                              logic er, logic [2:0] emv, logic [23:0] emd, logic [2:0] eml,
                              logic ee, logic [7:0] edc);
    vec_t x;
    x.rst = r; x.v = v; x.d = d; x.l = l; x.sel = s; x.mr = mr;
    x.er = er; x.emv = emv; x.emd = emd; x.eml = eml; x.ee = ee; x.edc = edc;
    return x;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask
  task automatic run(input string tag, input vec_t x);
    logic [23:0] dm;
    @(negedge clk);
    rst         = x.rst;
    bus.s_valid = x.v;
    bus.s_data  = x.d;
    bus.s_last  = x.l;
    bus.sel     = x.sel;
    bus.m_ready = x.mr;
    #1;
    dm = {{8{x.emv[2]}}, {8{x.emv[1]}}, {8{x.emv[0]}}};
    chk({tag, ".s_ready"}, 32'(bus.s_ready), 32'(x.er));
    chk({tag, ".m_valid"}, 32'(bus.m_valid), 32'(x.emv));
    chk({tag, ".m_data"}, 32'(bus.m_data & dm), 32'(x.emd & dm));
    chk({tag, ".m_last"}, 32'(bus.m_last & x.emv), 32'(x.eml));
    chk({tag, ".err_sel"}, 32'(bus.err_sel), 32'(x.ee));
    chk({tag, ".drop_count"}, 32'(bus.drop_count), 32'(x.edc));
  endtask
  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; bus.s_valid = 1'b1; bus.s_data = 8'hA5; bus.s_last = 1'b1; bus.sel = 2'd1; bus.m_ready = 3'b111;
    repeat (2) @(posedge clk);
    tbl.push_back(mk(1, 1, 8'hA5, 1, 1, 7, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'hA5, 1, 1, 7, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hA5, 1, 1, 7, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 7, 1, 3'b010, 24'h00A500, 3'b010, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 7, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h10, 0, 2, 7, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h11, 0, 0, 7, 1, 3'b100, 24'h100000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h12, 0, 0, 7, 1, 3'b100, 24'h110000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h13, 1, 0, 7, 1, 3'b100, 24'h120000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 7, 1, 3'b100, 24'h130000, 3'b100, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 7, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h20, 0, 0, 6, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 8'h21, 0, 0, 6, 0, 3'b001, 24'h000020, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h21, 0, 0, 7, 1, 3'b001, 24'h000020, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h22, 1, 0, 7, 1, 3'b001, 24'h000021, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 7, 1, 3'b001, 24'h000022, 3'b001, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 7, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h30, 0, 3, 7, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h31, 0, 3, 7, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 8'h32, 1, 1, 7, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 7, 1, 0, 0, 0, 0, 1));
    for (int i = 0; i < tbl.size(); i++) begin
      run($sformatf("vec%0d", i), tbl[i]);
      if (i == 1) begin
        chk("reset.m_data", 32'(bus.m_data), 32'h0);
        chk("reset.m_last", 32'(bus.m_last), 32'h0);
      end
    end
    for (int k = 0; k < 300; k++)
      run($sformatf("sat%0d", k), mk(0, 1, 8'(k), 1, 3, 7, 1, 0, 0, 0, k > 0,
                                     (k + 1 > 255) ? 8'd255 : 8'(k + 1)));
    run("sat_tail", mk(0, 0, 8'h00, 0, 3, 7, 1, 0, 0, 0, 1, 255));
    run("sat_idle", mk(0, 0, 8'h00, 0, 1, 7, 1, 0, 0, 0, 0, 255));
    run("mid_b0", mk(0, 1, 8'h40, 0, 1, 7, 1, 0, 0, 0, 0, 255));
    run("mid_b1", mk(0, 1, 8'h41, 0, 1, 7, 1, 3'b010, 24'h004000, 0, 0, 255));
    run("mid_rst", mk(1, 1, 8'h42, 0, 1, 7, 0, 3'b010, 24'h004100, 0, 0, 255));
    run("post_b0", mk(0, 1, 8'h50, 1, 0, 7, 1, 0, 0, 0, 0, 0));
    run("post_out", mk(0, 0, 8'h00, 0, 0, 7, 1, 3'b001, 24'h000050, 3'b001, 0, 0));
    run("idle_b0", mk(0, 1, 8'h51, 1, 2, 7, 1, 0, 0, 0, 0, 0));
    run("idle_out", mk(0, 0, 8'h00, 0, 2, 7, 1, 3'b100, 24'h510000, 3'b100, 0, 0));
    run("idle_end", mk(0, 0, 8'h00, 0, 2, 7, 1, 0, 0, 0, 0, 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
